// File: rtl/vlane_pkg.sv
// vlane_pkg: shared lane constants and load-response bundle.
// Optional feature macro used by this slice: VLOAD_HAZARD_CHECK_EN.
package vlane_pkg;

    localparam int VREG_ADDR_W      = 5;
    localparam int LANES_DATA_WIDTH = 64;

    typedef struct packed {
        logic                        valid;
        logic [LANES_DATA_WIDTH-1:0] data;
    } vload_resp_t;

endpackage

// File: rtl/vload_return_queue_if.sv
// vload_return_queue_if: issue, memory-response and VRF write bundle.
// Optional feature macro (affects raw_hazard only): VLOAD_HAZARD_CHECK_EN.
interface vload_return_queue_if
    import vlane_pkg::*;
#(
    parameter int LANES_DATA_WIDTH = vlane_pkg::LANES_DATA_WIDTH,
    parameter int DEST_DEPTH       = 4,
    parameter int CNT_W            = $clog2(DEST_DEPTH + 1)
);
    logic                        wait_load_signal;
    logic [VREG_ADDR_W-1:0]      load_destination;
    logic                        mem_resp_valid;
    logic [LANES_DATA_WIDTH-1:0] mem_resp_data;
    logic                        mem_resp_ready;
    logic                        read_done;
    logic [VREG_ADDR_W-1:0]      load_data_destination;
    logic [LANES_DATA_WIDTH-1:0] data_from_load;
    logic [CNT_W-1:0]            pending_count;
    logic                        almost_full;
    logic [VREG_ADDR_W-1:0]      hazard_addr_1;
    logic [VREG_ADDR_W-1:0]      hazard_addr_2;
    logic [VREG_ADDR_W-1:0]      hazard_addr_3;
    logic                        raw_hazard;
    logic                        overflow_err;

    modport master (
        output wait_load_signal, load_destination,
        output mem_resp_valid, mem_resp_data,
        output hazard_addr_1, hazard_addr_2, hazard_addr_3,
        input  mem_resp_ready, read_done,
        input  load_data_destination, data_from_load,
        input  pending_count, almost_full,
        input  raw_hazard, overflow_err
    );

    modport slave (
        input  wait_load_signal, load_destination,
        input  mem_resp_valid, mem_resp_data,
        input  hazard_addr_1, hazard_addr_2, hazard_addr_3,
        output mem_resp_ready, read_done,
        output load_data_destination, data_from_load,
        output pending_count, almost_full,
        output raw_hazard, overflow_err
    );

endinterface

// File: rtl/vload_dest_fifo.sv
// vload_dest_fifo: circular FIFO exposing its storage and entry-valid map.
// Full pushes are ignored here; the caller flags them.
module vload_dest_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [W-1:0]     entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign entries = mem;

    // Storage write; contents need no reset since validity comes from cnt.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Slot i is live when its distance from the head is below the count.
    always_comb begin
        logic [PW-1:0] off;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            entry_valid[i] = (CW'(off) < cnt);
        end
    end

endmodule

// File: rtl/vload_return_queue.sv
// vload_return_queue: pairs in-order load responses with issued destinations.
// Macro VLOAD_HAZARD_CHECK_EN builds the RAW comparators; otherwise 0.
module vload_return_queue
    import vlane_pkg::*;
#(
    parameter int LANES_DATA_WIDTH = vlane_pkg::LANES_DATA_WIDTH,
    parameter int DEST_DEPTH       = 4,
    parameter int CNT_W            = $clog2(DEST_DEPTH + 1)
) (
    input logic                 clk,
    input logic                 rst,
    vload_return_queue_if.slave bus
);
    logic                        full;
    logic                        empty;
    logic                        accept;
    logic [CNT_W-1:0]            count;
    logic [VREG_ADDR_W-1:0]      head;
    logic [VREG_ADDR_W-1:0]      entries [DEST_DEPTH];
    logic [DEST_DEPTH-1:0]       entry_valid;
    logic                        rd_q;
    logic [VREG_ADDR_W-1:0]      dest_q;
    logic [LANES_DATA_WIDTH-1:0] data_q;
    logic                        ovf_q;
    logic                        hazard;

    assign accept = bus.mem_resp_valid && !empty;

    vload_dest_fifo #(
        .DEPTH (DEST_DEPTH),
        .W     (VREG_ADDR_W),
        .CW    (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (bus.wait_load_signal),
        .pop         (accept),
        .din         (bus.load_destination),
        .dout        (head),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entries     (entries),
        .entry_valid (entry_valid)
    );

    // VRF write port: one-cycle pulse after each accepted response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            rd_q <= accept;
            if (accept) begin
                dest_q <= head;
                data_q <= bus.mem_resp_data;
            end
        end
    end

    // Sticky flag for a load issued while the queue was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.wait_load_signal && full) begin
            ovf_q <= 1'b1;
        end
    end

`ifdef VLOAD_HAZARD_CHECK_EN
    // Match issue operands against queued loads and the in-flight write.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEST_DEPTH; i++) begin
            if (entry_valid[i] &&
                (entries[i] == bus.hazard_addr_1 ||
                 entries[i] == bus.hazard_addr_2 ||
                 entries[i] == bus.hazard_addr_3)) begin
                hazard = 1'b1;
            end
        end
        if (rd_q &&
            (dest_q == bus.hazard_addr_1 ||
             dest_q == bus.hazard_addr_2 ||
             dest_q == bus.hazard_addr_3)) begin
            hazard = 1'b1;
        end
    end
`else
    logic hazard_unused;

    // Comparators absent; fold their inputs into a sink.
    always_comb begin
        hazard        = 1'b0;
        hazard_unused = ^{bus.hazard_addr_1, bus.hazard_addr_2,
                          bus.hazard_addr_3, entry_valid};
        for (int i = 0; i < DEST_DEPTH; i++) begin
            hazard_unused = hazard_unused ^ (^entries[i]);
        end
    end
`endif

    assign bus.mem_resp_ready        = !empty;
    assign bus.read_done             = rd_q;
    assign bus.load_data_destination = dest_q;
    assign bus.data_from_load        = data_q;
    assign bus.pending_count         = count;
    assign bus.almost_full           = (count >= CNT_W'(DEST_DEPTH - 1));
    assign bus.raw_hazard            = hazard;
    assign bus.overflow_err          = ovf_q;

endmodule

// File: tb/tb_vload_return_queue.sv
// tb_vload_return_queue: directed plus random stimulus, queue-based scoreboard.
// Honours VLOAD_HAZARD_CHECK_EN when predicting raw_hazard.
module tb_vload_return_queue;
    import vlane_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [4:0]    d;
        logic [DW-1:0] x;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vload_return_queue_if #(
        .LANES_DATA_WIDTH (DW),
        .DEST_DEPTH       (DEPTH),
        .CNT_W            (CW)
    ) bus ();

    vload_return_queue #(
        .LANES_DATA_WIDTH (DW),
        .DEST_DEPTH       (DEPTH),
        .CNT_W            (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] mq [$];
    exp_t       eq [$];
    bit         m_ovf = 0;
    bit         m_rdv = 0;
    logic [4:0] m_rdd = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_mq(input logic [4:0] a);
        foreach (mq[i]) begin
            if (mq[i] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit hz_hit(input logic [4:0] a);
        return in_mq(a) || (m_rdv && m_rdd == a);
    endfunction

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic idle_inputs();
        bus.wait_load_signal = 1'b0;
        bus.load_destination = '0;
        bus.mem_resp_valid   = 1'b0;
        bus.mem_resp_data    = '0;
        bus.hazard_addr_1    = '0;
        bus.hazard_addr_2    = '0;
        bus.hazard_addr_3    = '0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, update model.
    task automatic step(input logic push, input logic [4:0] d,
                        input logic v, input logic [DW-1:0] dat,
                        input logic [4:0] h1, input logic [4:0] h2,
                        input logic [4:0] h3);
        bit         acc;
        bit         was_full;
        bit         exp_hz;
        logic [4:0] h;
        @(negedge clk);
        bus.wait_load_signal = push;
        bus.load_destination = d;
        bus.mem_resp_valid   = v;
        bus.mem_resp_data    = dat;
        bus.hazard_addr_1    = h1;
        bus.hazard_addr_2    = h2;
        bus.hazard_addr_3    = h3;
        #1;
`ifdef VLOAD_HAZARD_CHECK_EN
        exp_hz = hz_hit(h1) || hz_hit(h2) || hz_hit(h3);
`else
        exp_hz = 1'b0;
`endif
        chk("raw_hazard", 64'(bus.raw_hazard), 64'(exp_hz));
        chk("mem_resp_ready", 64'(bus.mem_resp_ready), 64'(mq.size() != 0));
        @(posedge clk);
        was_full = (mq.size() == DEPTH);
        acc      = v && (mq.size() != 0);
        m_rdv    = acc;
        if (acc) begin
            h = mq.pop_front();
            m_rdd = h;
            eq.push_back('{d: h, x: dat});
        end
        if (push) begin
            if (was_full) m_ovf = 1'b1;
            else mq.push_back(d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        mq.delete();
        eq.delete();
        m_ovf = 1'b0;
        m_rdv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: registered outputs checked just after every active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("pending_count", 64'(bus.pending_count), 64'(mq.size()));
            chk("almost_full", 64'(bus.almost_full),
                64'(mq.size() >= DEPTH - 1));
            chk("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
            chk("read_done", 64'(bus.read_done), 64'(eq.size() != 0));
            if (bus.read_done && eq.size() != 0) begin
                e = eq.pop_front();
                chk("load_dest", 64'(bus.load_data_destination), 64'(e.d));
                chk("load_data", bus.data_from_load, e.x);
            end
        end
    end

    initial begin
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        do_reset();

        #1;
        chk("rst_ready", 64'(bus.mem_resp_ready), 64'd0);
        chk("rst_read_done", 64'(bus.read_done), 64'd0);
        chk("rst_count", 64'(bus.pending_count), 64'd0);
        chk("rst_hazard", 64'(bus.raw_hazard), 64'd0);
        chk("rst_ovf", 64'(bus.overflow_err), 64'd0);
        chk("rst_dest", 64'(bus.load_data_destination), 64'd0);
        chk("rst_data", bus.data_from_load, 64'd0);

        // Single load
        step(1, 7, 0, 0, 31, 31, 31);
        step(0, 0, 1, 64'hDEAD_BEEF, 7, 0, 0);
        step(0, 0, 0, 0, 7, 7, 7);
        step(0, 0, 0, 0, 7, 7, 7);

        // Ordering and wrap
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 4, 0, 0, 3, 0, 0);
        step(0, 0, 1, rnd64(), 4, 9, 1);
        step(1, 9, 1, rnd64(), 2, 9, 0);
        step(0, 0, 1, rnd64(), 9, 3, 0);
        step(1, 10, 1, rnd64(), 10, 4, 0);
        step(0, 0, 1, rnd64(), 10, 0, 0);
        step(0, 0, 1, rnd64(), 10, 9, 0);
        step(0, 0, 0, 0, 10, 0, 0);
        step(0, 0, 0, 0, 10, 0, 0);

        // Simultaneous push and pop at count 2
        step(1, 20, 0, 0, 0, 0, 0);
        step(1, 21, 0, 0, 0, 0, 0);
        step(1, 5, 1, rnd64(), 20, 5, 0);
        step(0, 0, 1, rnd64(), 5, 0, 0);
        step(0, 0, 1, rnd64(), 5, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Overflow: fifth push dropped, flag sticky until reset
        for (int i = 0; i < 5; i++) begin
            step(1, 5'(11 + i), 0, 0, 15, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, rnd64(), 15, 14, 0);
        end
        step(0, 0, 0, 0, 15, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0);

        // Hazard lifetime across the read_done cycle
        step(1, 12, 0, 0, 0, 12, 0);
        step(0, 0, 0, 0, 0, 12, 0);
        step(0, 0, 1, rnd64(), 0, 12, 0);
        step(0, 0, 0, 0, 0, 12, 0);
        step(0, 0, 0, 0, 0, 12, 0);

        // Reset mid-operation
        step(1, 3, 0, 0, 0, 0, 0);
        step(1, 6, 0, 0, 0, 0, 0);
        step(1, 8, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 0, 1, rnd64(), 3, 6, 8);
        step(0, 0, 1, rnd64(), 3, 6, 8);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            a3 = 5'($urandom_range(0, 31));
            if (mq.size() != 0 && $urandom_range(0, 1) == 1) begin
                a2 = mq[$urandom_range(0, mq.size() - 1)];
            end
            if (m_rdv && $urandom_range(0, 3) == 0) a3 = m_rdd;
            step(1'($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)),
                 rnd64(), a1, a2, a3);
            if ($urandom_range(0, 150) == 0) do_reset();
        end

        // Drain with a bounded budget
        for (int k = 0; k < 10 && mq.size() != 0; k++) begin
            step(0, 0, 1, rnd64(), 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain_pending", 64'(mq.size()), 64'd0);
        chk("drain_expected", 64'(eq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
